lsu_mem_stage: RTL and testbench

Parametrised load/store unit for the MEM stage of the pipelined RV32I/RV64I core. It replaces the fixed 32-bit, single-cycle store-alignment and load-extension logic with a stalling unit. The unit holds a data-cache request stable until `data_resp`, generates the byte mask, aligns store data, and sign- or zero-extends load data. It also detects misaligned or illegal accesses and supports pipeline flush of an in-flight access. It sits between the EX/MEM buffer and the MEM/WB buffer, and it drives the D-cache port directly.

---
 rtl/lsu_mem_stage.sv | 184 ++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit for an RV32I/RV64I pipeline.
// Accepts one load or store from EX/MEM, holds the D-cache request stable
// until data_resp, and returns extended load data to MEM/WB.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   op_valid            EX/MEM holds a valid instruction
//   op_load, op_store   instruction class (never both)
//   op_funct3           RISC-V size/sign field
//   op_addr             effective address
//   op_wdata            rs2 value, not yet lane-aligned
//   op_rd               destination register of a load
//   flush               kill the MEM-stage instruction
//   stall               freeze IF through EX/MEM
//   data_read/write     D-cache request strobes, held while busy
//   data_addr           word-aligned request address
//   data_mbe            byte enables
//   data_wdata          lane-aligned store data
//   data_resp           one-cycle completion pulse from the cache
//   data_rdata          read data, valid with data_resp
//   wb_valid            one-cycle pulse: load result on wb_rd/wb_data
//   fault, fault_cause  one-cycle exception pulse and its cause
//                       (0 load misaligned, 1 store misaligned, 2 illegal size)
module lsu_mem_stage #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic              op_load,
  input  logic              op_store,
  input  logic [2:0]        op_funct3,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [XLEN-1:0]   op_wdata,
  input  logic [4:0]        op_rd,
  input  logic              flush,
  output logic              stall,
  output logic              data_read,
  output logic              data_write,
  output logic [ADDR_W-1:0] data_addr,
  output logic [XLEN/8-1:0] data_mbe,
  output logic [XLEN-1:0]   data_wdata,
  input  logic              data_resp,
  input  logic [XLEN-1:0]   data_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              fault,
  output logic [1:0]        fault_cause
);

  localparam int NB  = XLEN / 8;
  localparam int OFS = $clog2(NB);

  // Byte lanes [ofs, ofs + 2**sz) are enabled; lanes past NB fall away.
  function automatic logic [NB-1:0] byte_mask(input logic [1:0] sz,
                                              input logic [OFS-1:0] ofs);
    int lo;
    int hi;
    lo = int'(ofs);
    hi = lo + (1 << sz);
    for (int i = 0; i < NB; i++) byte_mask[i] = (i >= lo) && (i < hi);
  endfunction

  // Bring the addressed bytes down to lane 0, keep 2**sz bytes, then
  // sign-extend from the top kept bit unless funct3[2] asks for zero fill.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] raw,
                                                  input logic [OFS-1:0]  ofs,
                                                  input logic [2:0]      f3);
    logic [XLEN-1:0] sh;
    logic            fill;
    int              top;
    sh   = raw >> {ofs, 3'b000};
    top  = (8 << f3[1:0]) - 1;
    if (top > XLEN - 1) top = XLEN - 1;
    fill = 1'b0;
    for (int i = 0; i < XLEN; i++) if (i == top) fill = ~f3[2] & sh[i];
    for (int i = 0; i < XLEN; i++) load_extend[i] = (i <= top) ? sh[i] : fill;
  endfunction

  logic              r_busy;
  logic              r_kill;
  logic              r_load;
  logic [ADDR_W-1:0] r_addr;
  logic [OFS-1:0]    r_ofs;
  logic [2:0]        r_f3;
  logic [4:0]        r_rd;
  logic [NB-1:0]     r_mbe;
  logic [XLEN-1:0]   r_wdata;
  logic              r_wb_valid;
  logic [4:0]        r_wb_rd;
  logic [XLEN-1:0]   r_wb_data;
  logic              r_fault;
  logic [1:0]        r_cause;

  logic [1:0]     w_size;
  logic [OFS-1:0] w_ofs;
  logic [3:0]     w_lowmask;
  logic           w_illegal;
  logic           w_misal;
  logic           w_cand;
  logic           w_accept;
  logic           w_fault;
  logic [1:0]     w_cause;

  assign w_size    = op_funct3[1:0];
  assign w_ofs     = op_addr[OFS-1:0];
  assign w_lowmask = (4'd1 << w_size) - 4'd1;

  // Illegal size: doubleword on RV32, any unsigned store, LWU on RV32.
  assign w_illegal = ((XLEN == 32) && (w_size == 2'd3))
                   || (op_store && op_funct3[2])
                   || ((XLEN == 32) && op_load && (op_funct3 == 3'b110));
  assign w_misal   = |(w_ofs & w_lowmask[OFS-1:0]);

  // A memory op that could be taken this cycle if it were well formed.
  assign w_cand   = ~r_busy & op_valid & (op_load | op_store) & ~flush;
  assign w_accept = w_cand & ~w_illegal & ~w_misal;
  assign w_fault  = w_cand & (w_illegal | w_misal);
  assign w_cause  = w_illegal ? 2'd2 : (op_load ? 2'd0 : 2'd1);

  // Low in the response cycle so the pipeline advances on the same edge
  // that returns to IDLE; the held op is never taken twice.
  assign stall = w_accept | (r_busy & ~data_resp);

  assign data_read   = r_busy & r_load;
  assign data_write  = r_busy & ~r_load;
  assign data_addr   = r_busy ? r_addr  : '0;
  assign data_mbe    = r_busy ? r_mbe   : '0;
  assign data_wdata  = r_busy ? r_wdata : '0;
  assign wb_valid    = r_wb_valid;
  assign wb_rd       = r_wb_rd;
  assign wb_data     = r_wb_data;
  assign fault       = r_fault;
  assign fault_cause = r_cause;

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy     <= 1'b0;
      r_kill     <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_fault    <= 1'b0;
      r_cause    <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_fault    <= w_fault;
      if (w_fault) r_cause <= w_cause;
      if (w_accept) begin
        r_busy <= 1'b1;
        r_kill <= 1'b0;
      end else if (r_busy) begin
        if (data_resp) begin
          r_busy <= 1'b0;
          // A flush arriving together with the response still kills it.
          if (r_load && !(r_kill || flush)) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_rd;
            r_wb_data  <= load_extend(data_rdata, r_ofs, r_f3);
          end
        end else if (flush) begin
          r_kill <= 1'b1;
        end
      end
    end
  end

  // Request capture; only observed while busy, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_load  <= op_load;
      r_addr  <= {op_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
      r_ofs   <= w_ofs;
      r_f3    <= op_funct3;
      r_rd    <= op_rd;
      r_mbe   <= byte_mask(w_size, w_ofs);
      r_wdata <= op_wdata << {w_ofs, 3'b000};
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // RV32 instance
  logic        op_valid, op_load, op_store, flush, data_resp;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr, op_wdata, data_rdata;
  logic [4:0]  op_rd;
  logic        stall, data_read, data_write, wb_valid, fault;
  logic [31:0] data_addr, data_wdata, wb_data;
  logic [3:0]  data_mbe;
  logic [4:0]  wb_rd;
  logic [1:0]  fault_cause;

  // RV64 instance
  logic        b_op_valid, b_op_load, b_op_store, b_flush, b_data_resp;
  logic [2:0]  b_op_funct3;
  logic [31:0] b_op_addr, b_data_addr;
  logic [63:0] b_op_wdata, b_data_rdata, b_data_wdata, b_wb_data;
  logic [4:0]  b_op_rd, b_wb_rd;
  logic        b_stall, b_data_read, b_data_write, b_wb_valid, b_fault;
  logic [7:0]  b_data_mbe;
  logic [1:0]  b_fault_cause;

  lsu_mem_stage #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_load(op_load),
    .op_store(op_store), .op_funct3(op_funct3), .op_addr(op_addr),
    .op_wdata(op_wdata), .op_rd(op_rd), .flush(flush), .stall(stall),
    .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
    .data_mbe(data_mbe), .data_wdata(data_wdata), .data_resp(data_resp),
    .data_rdata(data_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .fault(fault), .fault_cause(fault_cause));

  lsu_mem_stage #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst), .op_valid(b_op_valid), .op_load(b_op_load),
    .op_store(b_op_store), .op_funct3(b_op_funct3), .op_addr(b_op_addr),
    .op_wdata(b_op_wdata), .op_rd(b_op_rd), .flush(b_flush), .stall(b_stall),
    .data_read(b_data_read), .data_write(b_data_write), .data_addr(b_data_addr),
    .data_mbe(b_data_mbe), .data_wdata(b_data_wdata), .data_resp(b_data_resp),
    .data_rdata(b_data_rdata), .wb_valid(b_wb_valid), .wb_rd(b_wb_rd),
    .wb_data(b_wb_data), .fault(b_fault), .fault_cause(b_fault_cause));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          waits;
    logic        bad;
    logic [1:0]  cause;
    logic [3:0]  mbe;
    logic [31:0] ewd;
    logic [31:0] ewb;
  } vec_t;

  // Full RV32 transaction: present op, hold it while stalled, answer after
  // 'waits' busy cycles, then check write-back.
  task automatic run_op(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits,
                        input logic [4:0] rdi, input logic bad, input logic [1:0] cause,
                        input logic [3:0] mbe, input logic [31:0] ewd, input logic [31:0] ewb);
    op_valid = 1'b1; op_load = ld; op_store = ~ld; op_funct3 = f3;
    op_addr = addr; op_wdata = wd; op_rd = rdi;
    #1;
    chk("stall_accept", stall, !bad);
    chk("idle_no_req", data_read | data_write, 0);
    step();
    if (bad) begin
      op_valid = 1'b0;
      chk("fault_pulse", fault, 1);
      chk("fault_cause", fault_cause, cause);
      chk("fault_no_req", data_read | data_write, 0);
      step();
      chk("fault_one_cycle", fault, 0);
    end else begin
      for (int w = 0; w <= waits; w++) begin
        if (w == waits) begin
          data_resp = 1'b1; data_rdata = rd;
        end
        #1;
        chk("req_read", data_read, ld);
        chk("req_write", data_write, !ld);
        chk("req_addr", data_addr, addr & 32'hFFFF_FFFC);
        chk("req_mbe", data_mbe, mbe);
        chk("req_wdata", data_wdata, ewd);
        chk("stall_busy", stall, w != waits);
        step();
      end
      data_resp = 1'b0; op_valid = 1'b0;
      chk("wb_valid", wb_valid, ld);
      if (ld) begin
        chk("wb_data", wb_data, ewb);
        chk("wb_rd", wb_rd, rdi);
      end
      chk("idle_after_resp", data_read | data_write, 0);
      step();
      chk("wb_one_cycle", wb_valid, 0);
    end
  endtask

  // Reference model from the architectural rules.
  task automatic model(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd,
                       output logic bad, output logic [1:0] cause, output logic [3:0] mbe,
                       output logic [31:0] ewd, output logic [31:0] ewb);
    int size, ofs;
    logic illegal;
    logic [63:0] v, m;
    size    = 1 << f3[1:0];
    ofs     = int'(addr % 4);
    illegal = (size == 8) || (!ld && f3[2]) || (ld && f3 == 3'b110);
    bad     = illegal || (ofs % size != 0);
    cause   = illegal ? 2'd2 : (ld ? 2'd0 : 2'd1);
    mbe     = 4'(((1 << size) - 1) << ofs);
    ewd     = wd << (8 * ofs);
    v = {32'd0, rd} >> (8 * ofs);
    m = (64'd1 << (8 * size)) - 64'd1;
    v = v & m;
    if (!f3[2] && v[8*size-1]) v = v | ~m;
    ewb = v[31:0];
  endtask

  task automatic run64(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [63:0] wd, input logic [63:0] rd, input logic [7:0] mbe,
                       input logic [63:0] ewd, input logic [63:0] ewb);
    b_op_valid = 1'b1; b_op_load = ld; b_op_store = ~ld; b_op_funct3 = f3;
    b_op_addr = addr; b_op_wdata = wd; b_op_rd = 5'd9;
    #1;
    chk("x64_stall", b_stall, 1);
    step();
    b_data_resp = 1'b1; b_data_rdata = rd;
    #1;
    chk("x64_req", {b_data_read, b_data_write}, {ld, !ld});
    chk("x64_addr", b_data_addr, addr & 32'hFFFF_FFF8);
    chk("x64_mbe", b_data_mbe, mbe);
    chk("x64_wdata", b_data_wdata, ewd);
    chk("x64_stall_resp", b_stall, 0);
    step();
    b_data_resp = 1'b0; b_op_valid = 1'b0;
    chk("x64_wb_valid", b_wb_valid, ld);
    if (ld) chk("x64_wb_data", b_wb_data, ewb);
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1'b1, 3'd0, 32'h1003, 32'h0,        32'h80FF1234, 3, 1'b0, 2'd0, 4'b1000, 32'h0,        32'hFFFFFF80};
    tbl[1]  = '{1'b0, 3'd1, 32'h2002, 32'hDEADBEEF, 32'h0,        1, 1'b0, 2'd0, 4'b1100, 32'hBEEF0000, 32'h0};
    tbl[2]  = '{1'b1, 3'd2, 32'h1002, 32'h0,        32'h0,        0, 1'b1, 2'd0, 4'b0000, 32'h0,        32'h0};
    tbl[3]  = '{1'b1, 3'd3, 32'h1000, 32'h0,        32'h0,        0, 1'b1, 2'd2, 4'b0000, 32'h0,        32'h0};
    tbl[4]  = '{1'b1, 3'd5, 32'h3002, 32'h0,        32'h80FF1234, 0, 1'b0, 2'd0, 4'b1100, 32'h0,        32'h000080FF};
    tbl[5]  = '{1'b1, 3'd1, 32'h3002, 32'h0,        32'h80FF1234, 2, 1'b0, 2'd0, 4'b1100, 32'h0,        32'hFFFF80FF};
    tbl[6]  = '{1'b0, 3'd0, 32'h4001, 32'h12345678, 32'h0,        0, 1'b0, 2'd0, 4'b0010, 32'h34567800, 32'h0};
    tbl[7]  = '{1'b0, 3'd2, 32'h4002, 32'h0,        32'h0,        0, 1'b1, 2'd1, 4'b0000, 32'h0,        32'h0};
    tbl[8]  = '{1'b0, 3'd4, 32'h4000, 32'h0,        32'h0,        0, 1'b1, 2'd2, 4'b0000, 32'h0,        32'h0};
    tbl[9]  = '{1'b1, 3'd6, 32'h4000, 32'h0,        32'h0,        0, 1'b1, 2'd2, 4'b0000, 32'h0,        32'h0};
    tbl[10] = '{1'b1, 3'd4, 32'h5002, 32'h0,        32'h80FF1234, 1, 1'b0, 2'd0, 4'b0100, 32'h0,        32'h000000FF};
    tbl[11] = '{1'b1, 3'd2, 32'h6000, 32'h0,        32'h80FF1234, 0, 1'b0, 2'd0, 4'b1111, 32'h0,        32'h80FF1234};
    tbl[12] = '{1'b0, 3'd1, 32'h0001, 32'h0,        32'h0,        0, 1'b1, 2'd1, 4'b0000, 32'h0,        32'h0};
    tbl[13] = '{1'b1, 3'd3, 32'h1001, 32'h0,        32'h0,        0, 1'b1, 2'd2, 4'b0000, 32'h0,        32'h0};
    tbl[14] = '{1'b1, 3'd0, 32'h1000, 32'h0,        32'h80FF1234, 0, 1'b0, 2'd0, 4'b0001, 32'h0,        32'h00000034};
    tbl[15] = '{1'b0, 3'd2, 32'h7000, 32'hCAFEF00D, 32'h0,        2, 1'b0, 2'd0, 4'b1111, 32'hCAFEF00D, 32'h0};

    rst = 1'b0;
    op_valid = 0; op_load = 0; op_store = 0; op_funct3 = 0; op_addr = 0;
    op_wdata = 0; op_rd = 0; flush = 0; data_resp = 0; data_rdata = 0;
    b_op_valid = 0; b_op_load = 0; b_op_store = 0; b_op_funct3 = 0; b_op_addr = 0;
    b_op_wdata = 0; b_op_rd = 0; b_flush = 0; b_data_resp = 0; b_data_rdata = 0;
    step(); step();
    chk("reset_outputs",
        {stall, data_read, data_write, data_addr, data_mbe, data_wdata, wb_valid, wb_rd, fault, fault_cause},
        0);
    chk("reset_wb_data", wb_data, 0);
    rst = 1'b1;
    step();

    // Table-driven vectors
    for (int i = 0; i < 16; i++)
      run_op(tbl[i].ld, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].rd, tbl[i].waits,
             5'(i + 3), tbl[i].bad, tbl[i].cause, tbl[i].mbe, tbl[i].ewd, tbl[i].ewb);

    // Randomized ops against the model
    for (int i = 0; i < 150; i++) begin
      logic ld, bad;
      logic [2:0] f3;
      logic [31:0] addr, wd, rd, ewd, ewb;
      logic [1:0] cause;
      logic [3:0] mbe;
      ld   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      wd   = ld ? 32'h0 : $urandom;
      rd   = $urandom;
      model(ld, f3, addr, wd, rd, bad, cause, mbe, ewd, ewb);
      run_op(ld, f3, addr, wd, rd, $urandom_range(0, 3), 5'($urandom_range(0, 31)),
             bad, cause, mbe, ewd, ewb);
    end

    // Flush in first BUSY cycle, response two cycles later, then SB
    op_valid = 1; op_load = 1; op_store = 0; op_funct3 = 3'd2; op_addr = 32'h7000; op_rd = 5'd7;
    #1; chk("flush_accept", stall, 1);
    step();
    flush = 1'b1;
    #1; chk("flush_req_held0", data_read, 1); chk("flush_stall0", stall, 1);
    step();
    flush = 1'b0; op_valid = 1'b0;
    #1; chk("flush_req_held1", data_read, 1); chk("flush_addr", data_addr, 32'h7000);
    chk("flush_stall1", stall, 1);
    step();
    data_resp = 1'b1; data_rdata = 32'h12345678;
    #1; chk("flush_req_held2", data_read, 1); chk("flush_stall_resp", stall, 0);
    step();
    data_resp = 1'b0;
    chk("flush_no_wb", wb_valid, 0);
    op_valid = 1; op_load = 0; op_store = 1; op_funct3 = 3'd0; op_addr = 32'h7003; op_wdata = 32'h000000A5;
    #1; chk("sb_accept_after_flush", stall, 1);
    step();
    data_resp = 1'b1;
    #1; chk("sb_write", data_write, 1); chk("sb_mbe", data_mbe, 4'b1000);
    chk("sb_wdata", data_wdata, 32'hA5000000); chk("sb_stall_resp", stall, 0);
    step();
    data_resp = 1'b0; op_valid = 1'b0;
    chk("sb_no_wb", wb_valid, 0); chk("sb_idle", data_write, 0);

    // A fault to leave a nonzero cause, then reset during BUSY
    run_op(1'b1, 3'd3, 32'h0, 32'h0, 32'h0, 0, 5'd1, 1'b1, 2'd2, 4'd0, 32'h0, 32'h0);
    op_valid = 1; op_load = 1; op_store = 0; op_funct3 = 3'd1; op_addr = 32'h0100; op_rd = 5'd4;
    step();
    op_valid = 1'b0;
    #1; chk("rst_busy_req", data_read, 1);
    rst = 1'b0;
    step();
    chk("rst_busy_outputs",
        {stall, data_read, data_write, data_addr, data_mbe, data_wdata, wb_valid, wb_rd, fault, fault_cause},
        0);
    chk("rst_busy_wb_data", wb_data, 0);
    rst = 1'b1; data_resp = 1'b1; data_rdata = 32'hFFFFFFFF;
    step();
    data_resp = 1'b0;
    chk("late_resp_no_wb", wb_valid, 0);
    chk("late_resp_idle", {stall, data_read}, 0);

    // RV64 instance
    run64(1'b1, 3'd6, 32'h14, 64'h0, 64'h8765_4321_0000_0000, 8'hF0, 64'h0, 64'h0000_0000_8765_4321);
    run64(1'b1, 3'd2, 32'h14, 64'h0, 64'h8765_4321_0000_0000, 8'hF0, 64'h0, 64'hFFFF_FFFF_8765_4321);
    run64(1'b0, 3'd2, 32'h04, 64'h1122_3344, 64'h0, 8'hF0, 64'h1122_3344_0000_0000, 64'h0);
    run64(1'b1, 3'd3, 32'h08, 64'h0, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
